// File: rtl/osnt_sume_nic_opl_multi.sv
// ---------------------------------------------------------------------------
// osnt_sume_nic_opl_multi
//
// Output-port lookup for a multi-port NIC. Each incoming packet is staged in
// a small fall-through FIFO. The packet's source-port field (one-hot, 8 bits,
// MAC i = bit 2i, CPU i = bit 2i+1) selects a destination that is written into
// the destination-port field of tuser on every beat. Packets with an invalid
// source field, or any packet seen while in drop-all mode, are discarded.
//
// Ports
//   axis_aclk, axis_aresetn  : clock, synchronous active-low reset
//   s_axis_*                 : AXI4-Stream slave (packet input)
//   m_axis_*                 : AXI4-Stream master (packet output)
//   mode                     : 0 NIC, 1 loopback, 2 drop-all, 3 same as NIC
//   dbg_state                : current FSM state (0 HEADER, 1 IN_PACKET, 2 DROP)
//   pkt_fwd_cnt/pkt_drop_cnt : packet counters, present only when the macro
//                              OSNT_NIC_OPL_STATS_EN is defined
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends combinationally on ready of the same interface,
// and the slave side has no combinational path to the master side.
// ---------------------------------------------------------------------------
module osnt_sume_nic_opl_multi #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          SRC_PORT_POS         = 16,
  parameter int          DST_PORT_POS         = 24,
  parameter int          NUM_MAC_PORTS        = 4,
  parameter int          FIFO_DEPTH_BITS      = 2,
  parameter logic [7:0]  DEFAULT_DST          = 8'h01
) (
  input  logic                                axis_aclk,
  input  logic                                axis_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic [1:0]                          mode,
  output logic [1:0]                          dbg_state
`ifdef OSNT_NIC_OPL_STATS_EN
  ,
  output logic [31:0]                         pkt_fwd_cnt,
  output logic [31:0]                         pkt_drop_cnt
`endif
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int FW    = DW + KW + UW + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  // Ready drops when only one free slot remains, so ready can come straight
  // from a register without risking overflow.
  localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  // Source bits at or above 2*NUM_MAC_PORTS name ports that do not exist.
  localparam logic [8:0] MASK9     = 9'((1 << (2 * NUM_MAC_PORTS)) - 1);
  localparam logic [7:0] PORT_MASK = MASK9[7:0];

  typedef enum logic [1:0] {
    ST_HEADER    = 2'd0,
    ST_IN_PACKET = 2'd1,
    ST_DROP      = 2'd2
  } state_t;

  // ---------------- input FIFO ----------------
  logic [FW-1:0]              mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_BITS:0]   count_q;
  logic                       empty, wr_en, rd_en;

  logic [DW-1:0] head_data;
  logic [KW-1:0] head_keep;
  logic [UW-1:0] head_user;
  logic          head_last;

  assign empty         = (count_q == '0);
  assign s_axis_tready = (count_q < NF_LEVEL);
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign {head_data, head_keep, head_user, head_last} = mem_q[rd_ptr_q];

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- header decode ----------------
  logic [7:0] src;
  logic [7:0] dec_dst;
  logic       dec_drop;

  assign src = head_user[SRC_PORT_POS +: 8];

  always_comb begin
    dec_dst  = '0;
    dec_drop = (|(src & (src - 8'd1))) | (|(src & ~PORT_MASK)) | (mode == 2'd2);
    if (src == 8'd0) begin
      dec_dst = DEFAULT_DST;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (src[2*i]) begin
          if (mode == 2'd1) dec_dst[2*i]   = 1'b1;
          else              dec_dst[2*i+1] = 1'b1;
        end
        if (src[2*i+1]) dec_dst[2*i] = 1'b1;
      end
    end
  end

  // ---------------- packet FSM ----------------
  state_t     state_q;
  logic [7:0] dst_q;
  logic       drop_q;
  logic [7:0] cur_dst;
  logic       cur_drop;

  // The first beat is steered by the live decode; later beats use the
  // values latched at the header, so mode changes mid-packet have no effect.
  assign cur_dst  = (state_q == ST_HEADER) ? dec_dst  : dst_q;
  assign cur_drop = (state_q == ST_HEADER) ? dec_drop : drop_q;

  // Dropped packets drain regardless of downstream ready.
  assign rd_en = !empty && (cur_drop || m_axis_tready);

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q <= ST_HEADER;
      dst_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HEADER: begin
          if (!empty) begin
            dst_q  <= dec_dst;
            drop_q <= dec_drop;
            if (rd_en && !head_last) state_q <= dec_drop ? ST_DROP : ST_IN_PACKET;
          end
        end
        ST_IN_PACKET, ST_DROP: begin
          if (rd_en && head_last) state_q <= ST_HEADER;
        end
        default: state_q <= ST_HEADER;
      endcase
    end
  end

  assign dbg_state = state_q;

  // ---------------- output ----------------
  assign m_axis_tdata  = head_data;
  assign m_axis_tkeep  = head_keep;
  assign m_axis_tlast  = head_last;
  assign m_axis_tvalid = !empty && !cur_drop;

  always_comb begin
    m_axis_tuser = head_user;
    m_axis_tuser[DST_PORT_POS +: 8] = cur_dst;
  end

`ifdef OSNT_NIC_OPL_STATS_EN
  logic [31:0] fwd_cnt_q, drop_cnt_q;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (rd_en && head_last) begin
      if (cur_drop) drop_cnt_q <= drop_cnt_q + 32'd1;
      else          fwd_cnt_q  <= fwd_cnt_q + 32'd1;
    end
  end

  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_osnt_sume_nic_opl_multi.sv
// ---------------------------------------------------------------------------
// Testbench for osnt_sume_nic_opl_multi. Directed scenarios plus randomized
// packet batches, checked against a port-mapping model and an expected-beat
// queue. The DUT is built with three MAC ports so the upper source bits are
// out of range.
// ---------------------------------------------------------------------------
module tb_osnt_sume_nic_opl_multi;

  localparam int         DW      = 256;
  localparam int         KW      = 32;
  localparam int         UW      = 128;
  localparam int         BW      = DW + KW + UW + 1;
  localparam int         SRC_POS = 16;
  localparam int         DST_POS = 24;
  localparam int         NUM_MAC = 3;
  localparam logic [7:0] DEF_DST = 8'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast, m_tready;
  logic [1:0]    mode;
  logic [1:0]    dbg_state;
`ifdef OSNT_NIC_OPL_STATS_EN
  logic [31:0]   pkt_fwd_cnt, pkt_drop_cnt;
`endif

  osnt_sume_nic_opl_multi #(
    .NUM_MAC_PORTS (NUM_MAC),
    .DEFAULT_DST   (DEF_DST)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .mode          (mode),
    .dbg_state     (dbg_state)
`ifdef OSNT_NIC_OPL_STATS_EN
    ,
    .pkt_fwd_cnt   (pkt_fwd_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_fwd  = 0;
  int model_drop = 0;
  int cyc = 0;
  int out_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic force_low = 1'b0;
  logic bp_en     = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference mapping: find the set bit(s) of the source field and apply the
  // NIC / loopback port rules directly.
  task automatic model_port(input logic [7:0] s, input logic [1:0] md,
                            output logic drop, output logic [7:0] dst);
    int ones = 0;
    int k = 0;
    for (int i = 0; i < 8; i++) if (s[i]) begin ones++; k = i; end
    drop = (md == 2'd2) || (ones > 1) || ((int'(s) >> (2 * NUM_MAC)) != 0);
    if (ones == 0)      dst = DEF_DST;
    else if (k % 2 == 1) dst = 8'(1 << (k - 1));
    else if (md == 2'd1) dst = 8'(1 << k);
    else                 dst = 8'(1 << (k + 1));
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready: steady, randomly throttled, or held low.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = force_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (out_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_cnt++;
      if (exp_q.size() == 0) check("unexpected_beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, '0);
      else check("beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic [UW-1:0] u, input logic l);
    int w = 0;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && w < 200) begin w++; @(negedge clk); end
    check("s_tready_timeout", 32'(w < 200), 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] src, input int len, input logic [1:0] md,
                          input int pause, input logic [1:0] mode_after);
    logic drop;
    logic [7:0] dst;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u, eu;
    model_port(src, md, drop, dst);
    if (drop) model_drop++; else model_fwd++;
    for (int b = 0; b < len; b++) begin
      for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
      for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom();
      k = $urandom();
      u[SRC_POS +: 8] = src;
      eu = u;
      eu[DST_POS +: 8] = dst;
      if (!drop) exp_q.push_back({d, k, eu, (b == len - 1)});
      drive_beat(d, k, u, (b == len - 1));
      if (b == 0 && pause > 0) begin
        repeat (pause) @(posedge clk);
        #1;
        mode = mode_after;
      end
    end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin @(posedge clk); w++; end
    repeat (8) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
`ifdef OSNT_NIC_OPL_STATS_EN
    check({tag, "_fwd_cnt"},  pkt_fwd_cnt,  model_fwd);
    check({tag, "_drop_cnt"}, pkt_drop_cnt, model_drop);
`else
    check({tag, "_idle_state"}, dbg_state, 2'd0);
`endif
  endtask

  function automatic logic [7:0] rand_src();
    int c = $urandom_range(0, 9);
    int a, b;
    if (c < 6) return 8'(1 << $urandom_range(0, 2 * NUM_MAC - 1));
    if (c == 6) return 8'h00;
    if (c == 7) return 8'(1 << $urandom_range(2 * NUM_MAC, 7));
    a = $urandom_range(0, 7);
    b = (a + $urandom_range(1, 7)) % 8;
    return 8'((1 << a) | (1 << b));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic seen_low;
    aresetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    check("reset_m_tvalid", m_tvalid, 1'b0);
    check("reset_s_tready", s_tready, 1'b1);
    check("reset_state", dbg_state, 2'd0);
    check_counts("reset");
    @(posedge clk); #1;

    // Invalid source dropped, following valid packet delivered.
    send_pkt(8'h05, 3, 2'd0, 0, 2'd0);
    send_pkt(8'h01, 2, 2'd0, 0, 2'd0);
    drain("drop_then_fwd_drain");
    check_counts("drop_then_fwd");

    // NIC mode, MAC1 -> CPU1.
    send_pkt(8'h04, 3, 2'd0, 0, 2'd0);
    drain("nic_drain");

    // Loopback: CPU0 -> MAC0, zero source -> default.
    mode = 2'd1;
    send_pkt(8'h02, 2, 2'd1, 0, 2'd0);
    send_pkt(8'h00, 2, 2'd1, 0, 2'd0);
    drain("loopback_drain");

    // Mode flips mid-packet: current packet stays NIC, next uses loopback.
    mode = 2'd0;
    send_pkt(8'h01, 3, 2'd0, 4, 2'd1);
    send_pkt(8'h01, 2, 2'd1, 0, 2'd0);
    drain("mode_switch_drain");

    // Back-to-back packets leave no idle cycle on the output.
    mode = 2'd0;
    out_cnt = 0;
    send_pkt(8'h01, 2, 2'd0, 0, 2'd0);
    send_pkt(8'h10, 2, 2'd0, 0, 2'd0);
    send_pkt(8'h08, 2, 2'd0, 0, 2'd0);
    drain("b2b_drain");
    check("b2b_beats", out_cnt, 6);
    check("b2b_span", last_cyc - first_cyc, 5);

    // Downstream stalled for 20 cycles during continuous input.
    force_low = 1'b1;
    seen_low = 1'b0;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(8'h20, 3, 2'd0, 0, 2'd0);
      end
      begin
        repeat (2) @(posedge clk);
        repeat (20) begin
          @(negedge clk);
          if (!s_tready) seen_low = 1'b1;
        end
        force_low = 1'b0;
      end
    join
    check("stall_tready_low", seen_low, 1'b1);
    drain("stall_drain");
    check_counts("stall");

    // Randomized batches, mode fixed within a batch.
    for (int bt = 0; bt < 6; bt++) begin
      mode = 2'($urandom_range(0, 3));
      bp_en = 1'b1;
      for (int p = 0; p < 8; p++) send_pkt(rand_src(), $urandom_range(1, 4), mode, 0, 2'd0);
      drain("rand_drain");
      bp_en = 1'b0;
      check_counts("rand");
    end

    // Reset during a packet: the partial packet must never appear.
    mode = 2'd0;
    force_low = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_beat({8{32'hA5A5_0001}}, '1, 128'(32'h0001_0000), 1'b0);
    drive_beat({8{32'hA5A5_0002}}, '1, 128'(32'h0001_0000), 1'b0);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    force_low = 1'b0;
    model_fwd = 0;
    model_drop = 0;
    @(negedge clk);
    check("midreset_m_tvalid", m_tvalid, 1'b0);
    check("midreset_s_tready", s_tready, 1'b1);
    check("midreset_state", dbg_state, 2'd0);
    @(posedge clk); #1;
    send_pkt(8'h02, 4, 2'd0, 0, 2'd0);
    drain("after_reset_drain");
    check_counts("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
